tmip_action_ctrl: RTL and testbench
===================================

TMIP_ACTION_CTRL -- requirements
Module: tmip_action_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have port size_valid, input, 1 bit: img_size qualifier, pulsed on the first in_valid beat of an image.
REQ-004 SHALL have port img_size, input, 5 bits: initial image side; legal values 4, 8, 16.
REQ-005 SHALL have port in_valid_2, input, 1 bit: action beat qualifier.
REQ-006 SHALL have port action, input, 3 bits: 0 = correlate/terminate, 1 = maxpool, 2 = hflip, 3 = vflip, 4 = ldiag flip, 5 = rdiag flip, 6 = zoom, 7 = shortcut.
REQ-007 SHALL have port op_start, output, 1 bit: one-cycle command strobe to the datapath.
REQ-008 SHALL have port op_code, output, 3 bits: action being issued; valid while op_start=1.
REQ-009 SHALL have port op_size, output, 5 bits: image side before this action; valid while op_start=1.
REQ-010 SHALL have port op_done, input, 1 bit: datapath completion pulse.
REQ-011 SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 SHALL have port seq_done, output, 1 bit: one-cycle pulse after the final correlate completes.
REQ-013 SHALL have port final_size, output, 5 bits: size used for the correlate; held until the next size_valid.
REQ-014 SHALL have port ovf, output, 1 bit: sticky flag for a dropped action; cleared by size_valid.

Function
REQ-015 SHALL implement FSM states IDLE, COLLECT, ISSUE, WAIT, FINISH.
REQ-016 IDLE: size_valid latches img_size into cur_size and moves to COLLECT.
REQ-017 COLLECT: each in_valid_2 beat with a nonzero action enqueues it into a 16-entry x 3-bit queue.
REQ-018 COLLECT cancellation: a flip (2..5) equal to the queue tail SHALL pop the tail instead of pushing; applies only to consecutive beats, and only when the queue is non-empty.
REQ-019 COLLECT, queue full: a nonzero action with the queue full (16 entries) SHALL be dropped and set ovf; cancellation still applies when full.
REQ-020 COLLECT: action 0 SHALL enqueue 0 (a reserved 17th slot) and move to ISSUE; op_start SHALL rise the cycle after action 0 is sampled.
REQ-021 ISSUE: op_start=1 for exactly one cycle with op_code = queue head and op_size = cur_size; then move to WAIT.
REQ-022 WAIT: on op_done, update cur_size and pop the head.
REQ-023 WAIT, next state after op_done: if the popped code was 0, go to FINISH; otherwise go to ISSUE, so the next op_start is 1 cycle after op_done.
REQ-024 Size rule, codes 1 and 7: cur_size halves if cur_size > 4, else unchanged.
REQ-025 Size rule, code 6: cur_size doubles if cur_size < 16, else unchanged.
REQ-026 Size rule, all other codes: cur_size unchanged.
REQ-027 Size arithmetic SHALL be shifts only; cur_size SHALL never leave {4, 8, 16}.
REQ-028 FINISH: seq_done=1 for one cycle, final_size = cur_size, clear queue, go to IDLE.
REQ-029 op_done outside WAIT SHALL be ignored.
REQ-030 in_valid_2 outside COLLECT SHALL be ignored.
REQ-031 size_valid outside IDLE SHALL be ignored.
REQ-032 Simultaneous op_done and op_start cannot occur: op_start is only driven in ISSUE.

Reset
REQ-033 Reset SHALL clear the following, overriding any in-flight operation (e.g. a pending op_done): state = IDLE, op_start = 0, op_code = 0, op_size = 0, busy = 0, seq_done = 0, final_size = 0, ovf = 0, cur_size = 0, queue pointers and count = 0.

Structure
REQ-034 A shared package SHALL hold the action-code constants, the FSM state enum, QDEPTH = 16 and the legal size constants.
REQ-035 The queue SHALL be a sub-module tmip_act_queue with push, pop, pop_tail, head, tail, full and empty.

Verification
REQ-036 Size 8; actions 1,0; op_done returned 3 cycles after each op_start -> issues (1,8) then (0,4); seq_done once; final_size = 4.
REQ-037 Size 4; actions 2,2,3,0 -> issues only (3,4) and (0,4); the hflip pair is cancelled.
REQ-038 Size 16; actions 6,7,7,7,0 -> op_size sequence 16,16,8,4,4; final_size = 4.
REQ-039 Size 8; 17 nonzero non-cancelling actions then 0 -> ovf = 1; exactly 16 non-zero issues plus the correlate.
REQ-040 Reset asserted during WAIT -> next cycle busy = 0 and all outputs 0; a later op_done is ignored; a new size_valid restarts normally.
REQ-041 Spurious op_done in IDLE and an in_valid_2 beat during ISSUE -> no state change and no enqueue.

Source files
------------

// File: rtl/tmip_action_ctrl_pkg.sv
// tmip_action_ctrl_pkg: action codes, FSM states, queue depth, legal sizes and the size-update rule
package tmip_action_ctrl_pkg;
  localparam int QDEPTH = 16;
  localparam logic [4:0] SZ_MIN = 5'd4;
  localparam logic [4:0] SZ_MID = 5'd8;
  localparam logic [4:0] SZ_MAX = 5'd16;
  localparam logic [2:0] ACT_CORR = 3'd0;
  localparam logic [2:0] ACT_MAXPOOL = 3'd1;
  localparam logic [2:0] ACT_HFLIP = 3'd2;
  localparam logic [2:0] ACT_VFLIP = 3'd3;
  localparam logic [2:0] ACT_LDIAG = 3'd4;
  localparam logic [2:0] ACT_RDIAG = 3'd5;
  localparam logic [2:0] ACT_ZOOM = 3'd6;
  localparam logic [2:0] ACT_SHORT = 3'd7;
  typedef enum logic [2:0] {IDLE, COLLECT, ISSUE, WAIT, FINISH} state_t;
  function automatic logic is_flip(input logic [2:0] a);
    return a >= ACT_HFLIP && a <= ACT_RDIAG;
  endfunction
  function automatic logic [4:0] next_size(input logic [2:0] a, input logic [4:0] s);
    return (a == ACT_MAXPOOL || a == ACT_SHORT) ? (s > SZ_MIN ? s >> 1 : s) :
           a == ACT_ZOOM ? (s < SZ_MAX ? s << 1 : s) : s;
  endfunction
endpackage

// File: rtl/tmip_act_queue.sv
// tmip_act_queue: 16+1 entry action queue; ports clk/rst/clr, push/pop/pop_tail with din, head/tail/full/empty
module tmip_act_queue
  import tmip_action_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic       pop_tail,
  input  logic [2:0] din,
  output logic [2:0] head,
  output logic [2:0] tail,
  output logic       full,
  output logic       empty
);
  logic [2:0] mem [QDEPTH+1];
  logic [4:0] rd, wr, cnt;
  assign cnt = wr - rd;
  assign empty = cnt == 5'd0;
  assign full = cnt >= 5'(QDEPTH);
  assign head = empty ? 3'd0 : mem[rd];
  assign tail = empty ? 3'd0 : mem[wr - 5'd1];
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      rd <= '0;
      wr <= '0;
    end else begin
      if (push) begin
        mem[wr] <= din;
        wr <= wr + 5'd1;
      end else if (pop_tail) wr <= wr - 5'd1;
      if (pop) rd <= rd + 5'd1;
    end
  end
endmodule

// File: rtl/tmip_action_ctrl.sv
// tmip_action_ctrl: collects image actions, cancels flip pairs, issues them to the datapath (op_*), reports busy/seq_done/final_size/ovf
module tmip_action_ctrl
  import tmip_action_ctrl_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       size_valid,
  input  logic [4:0] img_size,
  input  logic       in_valid_2,
  input  logic [2:0] action,
  output logic       op_start,
  output logic [2:0] op_code,
  output logic [4:0] op_size,
  input  logic       op_done,
  output logic       busy,
  output logic       seq_done,
  output logic [4:0] final_size,
  output logic       ovf
);
  state_t state, next;
  logic [4:0] cur_size;
  logic push, pop, pop_tail, drop, full, empty;
  logic [2:0] head, tail;
  tmip_act_queue u_queue (
    .clk(clk), .rst(rst), .clr(seq_done), .push(push), .pop(pop), .pop_tail(pop_tail),
    .din(action), .head(head), .tail(tail), .full(full), .empty(empty)
  );
  assign op_start = state == ISSUE;
  assign op_code = op_start ? head : 3'd0;
  assign op_size = op_start ? cur_size : 5'd0;
  assign busy = state != IDLE;
  assign seq_done = state == FINISH;
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= next;
  end
  always_comb begin
    next = state;
    push = 1'b0;
    pop = 1'b0;
    pop_tail = 1'b0;
    drop = 1'b0;
    case (state)
      IDLE: next = size_valid ? COLLECT : IDLE;
      COLLECT:
        if (in_valid_2) begin
          // the correlate always fits: it owns the reserved 17th slot
          if (action == ACT_CORR) begin
            push = 1'b1;
            next = ISSUE;
          end else if (is_flip(action) && !empty && tail == action) pop_tail = 1'b1;
          else if (full) drop = 1'b1;
          else push = 1'b1;
        end
      ISSUE: next = WAIT;
      WAIT:
        if (op_done) begin
          pop = 1'b1;
          next = head == ACT_CORR ? FINISH : ISSUE;
        end
      FINISH: next = IDLE;
      default: next = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_size <= '0;
      final_size <= '0;
      ovf <= 1'b0;
    end else begin
      if (state == IDLE && size_valid) begin
        cur_size <= img_size;
        ovf <= 1'b0;
      end
      if (drop) ovf <= 1'b1;
      if (state == WAIT && op_done) begin
        cur_size <= next_size(head, cur_size);
        if (head == ACT_CORR) final_size <= cur_size;
      end
    end
  end
endmodule

// File: tb/tb_tmip_action_ctrl.sv
// tb_tmip_action_ctrl: scoreboard bench with a queue-level reference model and a delayed op_done responder
module tb_tmip_action_ctrl;
  logic clk = 0, rst = 1, size_valid = 0, in_valid_2 = 0, op_done = 0;
  logic [4:0] img_size = 0;
  logic [2:0] action = 0;
  logic op_start, busy, seq_done, ovf;
  logic [2:0] op_code;
  logic [4:0] op_size, final_size;
  typedef struct {int code; int size;} op_t;
  op_t exp_ops[$];
  op_t e;
  int exp_final[$];
  int checks = 0, failures = 0, done_cnt = 0, op_cnt = 0, resp_delay = 3;
  tmip_action_ctrl dut (
    .clk(clk), .rst(rst), .size_valid(size_valid), .img_size(img_size), .in_valid_2(in_valid_2),
    .action(action), .op_start(op_start), .op_code(op_code), .op_size(op_size), .op_done(op_done),
    .busy(busy), .seq_done(seq_done), .final_size(final_size), .ovf(ovf)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    if (op_start) begin
      op_cnt++;
      if (exp_ops.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_issue: got code %0d size %0d with nothing expected", op_code, op_size);
      end else begin
        e = exp_ops.pop_front();
        check("op_code", int'(op_code), e.code);
        check("op_size", int'(op_size), e.size);
      end
    end
    if (seq_done) begin
      done_cnt++;
      check("ops_left_at_done", exp_ops.size(), 0);
      if (exp_final.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_seq_done: got final_size %0d with nothing expected", final_size);
      end else check("final_size", int'(final_size), exp_final.pop_front());
    end
  end
  initial forever begin
    @(negedge clk);
    if (op_start) begin
      repeat (resp_delay) @(posedge clk);
      #1 op_done = 1;
      @(posedge clk);
      #1 op_done = 0;
    end
  end
  task automatic beat(input int a);
    in_valid_2 = 1;
    action = 3'(a);
    @(posedge clk);
    #1 in_valid_2 = 0;
  endtask
  task automatic run_image(input int sz, input int acts[$]);
    int q[$];
    int s, d0;
    bit ovf_e;
    s = sz;
    ovf_e = 0;
    foreach (acts[i]) begin
      if (acts[i] >= 2 && acts[i] <= 5 && q.size() > 0 && q[q.size()-1] == acts[i]) void'(q.pop_back());
      else if (q.size() >= 16) ovf_e = 1;
      else q.push_back(acts[i]);
    end
    q.push_back(0);
    foreach (q[i]) begin
      exp_ops.push_back('{q[i], s});
      if ((q[i] == 1 || q[i] == 7) && s > 4) s = s / 2;
      else if (q[i] == 6 && s < 16) s = s * 2;
    end
    exp_final.push_back(s);
    d0 = done_cnt;
    size_valid = 1;
    img_size = 5'(sz);
    @(posedge clk);
    #1 size_valid = 0;
    check("busy_collect", int'(busy), 1);
    foreach (acts[i]) begin
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #0 beat(acts[i]);
    end
    in_valid_2 = 1;
    action = 0;
    @(posedge clk);
    #1 action = 3'($urandom_range(1, 7));
    @(posedge clk);
    #1 in_valid_2 = 0;
    for (int c = 0; c < 3000 && done_cnt == d0; c++) @(posedge clk);
    #1 check("seq_done_count", done_cnt, d0 + 1);
    check("ovf", int'(ovf), int'(ovf_e));
    @(posedge clk);
    #1 check("busy_after_done", int'(busy), 0);
    check("final_size_held", int'(final_size), s);
  endtask
  initial begin
    int acts[$];
    int d0, o0, sizes[3];
    sizes = '{4, 8, 16};
    repeat (3) @(posedge clk);
    #1 rst = 0;
    check("rst_busy", int'(busy), 0);
    check("rst_op_start", int'(op_start), 0);
    check("rst_final_size", int'(final_size), 0);
    check("rst_ovf", int'(ovf), 0);
    acts = '{1};
    run_image(8, acts);
    acts = '{2, 2, 3};
    run_image(4, acts);
    acts = '{6, 7, 7, 7};
    run_image(16, acts);
    acts = {};
    for (int i = 0; i < 17; i++) acts.push_back(i % 2 ? 6 : 1);
    run_image(8, acts);
    resp_delay = 10;
    exp_ops.push_back('{1, 8});
    exp_ops.push_back('{0, 4});
    exp_final.push_back(4);
    o0 = op_cnt;
    size_valid = 1;
    img_size = 8;
    @(posedge clk);
    #1 size_valid = 0;
    beat(1);
    beat(0);
    for (int c = 0; c < 50 && op_cnt == o0; c++) @(posedge clk);
    #1 check("rst_test_issue_seen", op_cnt, o0 + 1);
    @(posedge clk);
    #1 rst = 1;
    @(posedge clk);
    #1 rst = 0;
    check("wait_rst_busy", int'(busy), 0);
    check("wait_rst_op_start", int'(op_start), 0);
    check("wait_rst_op_code", int'(op_code), 0);
    check("wait_rst_op_size", int'(op_size), 0);
    check("wait_rst_seq_done", int'(seq_done), 0);
    check("wait_rst_final_size", int'(final_size), 0);
    check("wait_rst_ovf", int'(ovf), 0);
    exp_ops.delete();
    exp_final.delete();
    d0 = done_cnt;
    o0 = op_cnt;
    repeat (15) @(posedge clk);
    #1 check("late_op_done_busy", int'(busy), 0);
    check("late_op_done_no_seq", done_cnt, d0);
    check("late_op_done_no_issue", op_cnt, o0);
    resp_delay = 3;
    acts = '{3, 6};
    run_image(4, acts);
    for (int n = 0; n < 25; n++) begin
      op_done = 1;
      @(posedge clk);
      #1 op_done = 0;
      check("spurious_op_done_idle", int'(busy), 0);
      acts = {};
      repeat ($urandom_range(0, 20)) begin
        if (acts.size() > 0 && $urandom_range(0, 3) == 0) acts.push_back(acts[acts.size()-1]);
        else acts.push_back($urandom_range(1, 7));
      end
      resp_delay = $urandom_range(1, 4);
      run_image(sizes[$urandom_range(0, 2)], acts);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
